// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Function : Round-robin sharing of one memory port between ICache refills
//             and DCache refills/writebacks, one fixed-length burst per grant.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter  int BURST_LEN = 4,
  localparam int BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_rvalid,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_rvalid,
  output logic          d_done,
  output logic [BW-1:0] beat_idx,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam logic [1:0]    c_IDLE   = 2'd0;
  localparam logic [1:0]    c_BUSY_I = 2'd1;
  localparam logic [1:0]    c_BUSY_D = 2'd2;
  localparam logic [1:0]    c_FINISH = 2'd3;
  localparam logic [BW-1:0] c_LAST   = BW'(BURST_LEN - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic          r_last_d;      // owner of the most recent grant: 1 = DCache
  logic [31:0]   r_base;
  logic          r_we;
  logic [BW-1:0] r_beat;
  logic [31:0]   r_i_rdata;
  logic [31:0]   r_d_rdata;
  logic          r_i_rvalid;
  logic          r_d_rvalid;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_in_beat;
  logic          w_last_beat;

  assign w_in_beat   = (r_state == c_BUSY_I) || (r_state == c_BUSY_D);
  assign w_last_beat = (r_beat == c_LAST);

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (r_state == c_IDLE) begin
      if (i_req && d_req) begin
        w_grant_i = r_last_d;
        w_grant_d = !r_last_d;
      end else begin
        w_grant_i = i_req;
        w_grant_d = d_req;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= c_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: a burst leaves its BUSY state only when the last beat is acked.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant_d)      w_next = c_BUSY_D;
        else if (w_grant_i) w_next = c_BUSY_I;
      end
      c_BUSY_I, c_BUSY_D: begin
        if (mem_ack && w_last_beat) w_next = c_FINISH;
      end
      c_FINISH: w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  // Grant bookkeeping, beat counter and registered read-data return.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_d   <= 1'b0;
      r_base     <= 32'd0;
      r_we       <= 1'b0;
      r_beat     <= '0;
      r_i_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_i_rvalid <= (r_state == c_BUSY_I) && mem_ack;
      r_d_rvalid <= (r_state == c_BUSY_D) && mem_ack && !r_we;
      if ((r_state == c_BUSY_I) && mem_ack) r_i_rdata <= mem_rdata;
      if ((r_state == c_BUSY_D) && mem_ack && !r_we) r_d_rdata <= mem_rdata;
      if (w_grant_i || w_grant_d) begin
        r_base   <= w_grant_d ? d_addr : i_addr;
        r_we     <= w_grant_d && d_we;
        r_beat   <= '0;
        r_last_d <= w_grant_d;
      end else if (w_in_beat && mem_ack && !w_last_beat) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Outputs decoded from state; memory request fields are stable until ack.
  always_comb begin
    mem_en    = w_in_beat;
    mem_we    = (r_state == c_BUSY_D) && r_we;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (w_in_beat) mem_addr = r_base + {{(30-BW){1'b0}}, r_beat, 2'b00};
    if ((r_state == c_BUSY_D) && r_we) mem_wdata = d_wdata;
    i_done    = (r_state == c_FINISH) && !r_last_d;
    d_done    = (r_state == c_FINISH) && r_last_d;
    busy      = (r_state != c_IDLE);
  end

  assign i_rdata  = r_i_rdata;
  assign i_rvalid = r_i_rvalid;
  assign d_rdata  = r_d_rdata;
  assign d_rvalid = r_d_rvalid;
  assign beat_idx = r_beat;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Function : Directed table-driven and sequence checks for mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h100;
  logic [31:0] i_rdata;
  logic        i_rvalid, i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h3000;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_rvalid, d_done;
  logic [1:0]  beat_idx;
  logic        busy, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  // Memory returns its own address as data; DCache supplies 0xA0+beat.
  assign mem_rdata = mem_addr;
  assign d_wdata   = 32'hA0 + 32'(beat_idx);

  mem_port_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .d_done(d_done), .beat_idx(beat_idx), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  in;    // {rst, i_req, d_req, d_we, mem_ack}
    logic [6:0]  exp;   // {mem_en, mem_we, busy, i_rvalid, d_rvalid, i_done, d_done}
    logic [31:0] addr;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ack every beat until the done pulse of the given side, counting read pulses.
  task automatic ack_until_done(input bit is_d, input int exp_rv, input string nm);
    int  rv = 0;
    bit  seen = 1'b0;
    mem_ack = 1'b1;
    for (int n = 0; n < 32; n++) begin
      step();
      rv += is_d ? int'(d_rvalid) : int'(i_rvalid);
      if (is_d ? d_done : i_done) begin
        seen = 1'b1;
        break;
      end
    end
    mem_ack = 1'b0;
    chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    chk({nm, "_rvalid_count"}, 32'(rv), 32'(exp_rv));
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    chk({nm, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  // DCache writeback at 0x2000 with an optional ack stall on one beat.
  task automatic d_write(input int stall_beat, input int stall_cyc, input string nm);
    d_addr = 32'h2000;
    d_we   = 1'b1;
    d_req  = 1'b1;
    mem_ack = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == stall_beat) begin
        for (int j = 0; j < stall_cyc; j++) begin
          chk({nm, "_stall_en"},    32'(mem_en), 32'd1);
          chk({nm, "_stall_addr"},  mem_addr,    32'h2000 + 32'(4 * k));
          chk({nm, "_stall_wdata"}, mem_wdata,   32'hA0 + 32'(k));
          step();
        end
      end
      chk({nm, "_en"},    32'(mem_en),   32'd1);
      chk({nm, "_we"},    32'(mem_we),   32'd1);
      chk({nm, "_addr"},  mem_addr,      32'h2000 + 32'(4 * k));
      chk({nm, "_wdata"}, mem_wdata,     32'hA0 + 32'(k));
      chk({nm, "_beat"},  32'(beat_idx), 32'(k));
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk({nm, "_no_drvalid"}, 32'(d_rvalid), 32'd0);
    end
    chk({nm, "_d_done"}, 32'(d_done), 32'd1);
    chk({nm, "_fin_en"}, 32'(mem_en), 32'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    step();
    chk({nm, "_single_done"}, 32'(d_done), 32'd0);
    chk({nm, "_idle"},        32'(busy),   32'd0);
  endtask

  initial begin
    // Tests 1 and 2: I-only refill, then reset and simultaneous requests.
    tbl[0]  = '{5'b00000, 7'b0000000, 32'h0,    32'h0};
    tbl[1]  = '{5'b11000, 7'b1010000, 32'h100,  32'h0};
    tbl[2]  = '{5'b11001, 7'b1011000, 32'h104,  32'h100};
    tbl[3]  = '{5'b11001, 7'b1011000, 32'h108,  32'h104};
    tbl[4]  = '{5'b11001, 7'b1011000, 32'h10C,  32'h108};
    tbl[5]  = '{5'b11001, 7'b0011010, 32'h0,    32'h10C};
    tbl[6]  = '{5'b10000, 7'b0000000, 32'h0,    32'h0};
    tbl[7]  = '{5'b01100, 7'b0000000, 32'h0,    32'h0};
    tbl[8]  = '{5'b11100, 7'b1010000, 32'h3000, 32'h0};
    tbl[9]  = '{5'b11101, 7'b1010100, 32'h3004, 32'h3000};
    tbl[10] = '{5'b11101, 7'b1010100, 32'h3008, 32'h3004};
    tbl[11] = '{5'b11101, 7'b1010100, 32'h300C, 32'h3008};
    tbl[12] = '{5'b11101, 7'b0010101, 32'h0,    32'h300C};
    tbl[13] = '{5'b11100, 7'b0000000, 32'h0,    32'h0};
    tbl[14] = '{5'b11100, 7'b1010000, 32'h100,  32'h0};
    tbl[15] = '{5'b11101, 7'b1011000, 32'h104,  32'h100};
    tbl[16] = '{5'b11101, 7'b1011000, 32'h108,  32'h104};
    tbl[17] = '{5'b11101, 7'b1011000, 32'h10C,  32'h108};
    tbl[18] = '{5'b11101, 7'b0011010, 32'h0,    32'h10C};
    tbl[19] = '{5'b10000, 7'b0000000, 32'h0,    32'h0};

    for (int i = 0; i < 20; i++) begin
      {rst, i_req, d_req, d_we, mem_ack} = tbl[i].in;
      step();
      chk($sformatf("row%0d_en", i),     32'(mem_en),   32'(tbl[i].exp[6]));
      chk($sformatf("row%0d_we", i),     32'(mem_we),   32'(tbl[i].exp[5]));
      chk($sformatf("row%0d_busy", i),   32'(busy),     32'(tbl[i].exp[4]));
      chk($sformatf("row%0d_irv", i),    32'(i_rvalid), 32'(tbl[i].exp[3]));
      chk($sformatf("row%0d_drv", i),    32'(d_rvalid), 32'(tbl[i].exp[2]));
      chk($sformatf("row%0d_idone", i),  32'(i_done),   32'(tbl[i].exp[1]));
      chk($sformatf("row%0d_ddone", i),  32'(d_done),   32'(tbl[i].exp[0]));
      chk($sformatf("row%0d_addr", i),   mem_addr,      tbl[i].addr);
      if (tbl[i].exp[3]) chk($sformatf("row%0d_irdata", i), i_rdata, tbl[i].rdata);
      if (tbl[i].exp[2]) chk($sformatf("row%0d_drdata", i), d_rdata, tbl[i].rdata);
    end
    mem_ack = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;

    // Test 3: zero-wait writeback.
    d_write(-1, 0, "t3");
    // Test 4: ack withheld for 3 cycles on beat 1.
    d_write(1, 3, "t4");

    // Test 5: reset during beat 2 of an I burst, request still held afterwards.
    i_req = 1'b1;
    step();
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    chk("t5_beat2", 32'(beat_idx), 32'd2);
    rst = 1'b0;
    step();
    chk("t5_rst_en",    32'(mem_en),   32'd0);
    chk("t5_rst_busy",  32'(busy),     32'd0);
    chk("t5_rst_idone", 32'(i_done),   32'd0);
    chk("t5_rst_irv",   32'(i_rvalid), 32'd0);
    chk("t5_rst_addr",  mem_addr,      32'd0);
    chk("t5_rst_beat",  32'(beat_idx), 32'd0);
    rst = 1'b1;
    step();
    chk("t5_regrant_en",   32'(mem_en),   32'd1);
    chk("t5_regrant_addr", mem_addr,      32'h100);
    chk("t5_regrant_beat", 32'(beat_idx), 32'd0);
    ack_until_done(1'b0, 4, "t5");

    // Test 6: i_req arrives mid D read burst and waits for the following IDLE.
    d_addr = 32'h3000;
    d_we   = 1'b0;
    d_req  = 1'b1;
    step();
    mem_ack = 1'b1;
    step();
    i_req = 1'b1;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 16; n++) begin
        chk("t6_no_i_rvalid", 32'(i_rvalid), 32'd0);
        if (mem_en) chk("t6_d_addr_only", mem_addr & 32'hFFFF_F000, 32'h3000);
        if (d_done) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      chk("t6_d_done_seen", 32'(seen), 32'd1);
    end
    mem_ack = 1'b0;
    d_req   = 1'b0;
    step();
    chk("t6_idle_busy", 32'(busy),   32'd0);
    chk("t6_idle_en",   32'(mem_en), 32'd0);
    step();
    chk("t6_i_grant_en",   32'(mem_en), 32'd1);
    chk("t6_i_grant_addr", mem_addr,    32'h100);
    ack_until_done(1'b0, 4, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
